// File: rtl/barrel_hit_detect.sv
`default_nettype none
// ============================================================================
// Module      : barrel_hit_detect
// Description : Game-side responder for the barrel block. Each cycle it
//               checks the barrel hitbox against Mario's hitbox, turns a
//               registered overlap into a hit (lose a life, brief
//               invulnerability) and counts barrels Mario has jumped over.
//               Drives `over` back to the barrel block once lives run out.
//
// Ports       : clk, rst (async, active-high)
//               start           - level, begins play from IDLE
//               barrel_x/_y     - barrel top-left position
//               barrel_state    - 00 idle, 01 rolling, 10 falling, 11 gone
//               mario_x/_y      - Mario top-left position
//               mario_jump      - Mario is airborne
//               over            - game over (to barrel.over)
//               lives           - remaining lives
//               score           - barrels jumped, saturates at 255
//               hit_flash       - high while in the HIT state
//
// Options     : define BARREL_HIT_DEBOUNCE_EN to require the registered
//               overlap on two consecutive edges before it counts as a hit.
//
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_hit_detect #(
    parameter int LIVES         = 3,
    parameter int BW            = 16,
    parameter int BH            = 16,
    parameter int MW            = 16,
    parameter int MH            = 16,
    parameter int INVULN_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] barrel_x,
    input  logic [8:0] barrel_y,
    input  logic [1:0] barrel_state,
    input  logic [9:0] mario_x,
    input  logic [8:0] mario_y,
    input  logic       mario_jump,
    output logic       over,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       hit_flash
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int TW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

    localparam logic [10:0]   C_BW          = 11'(BW);
    localparam logic [10:0]   C_MW          = 11'(MW);
    localparam logic [9:0]    C_BH          = 10'(BH);
    localparam logic [9:0]    C_MH          = 10'(MH);
    localparam logic [1:0]    C_LIVES       = 2'(LIVES);
    localparam logic [TW-1:0] C_TIMER_LOAD  = TW'(INVULN_CYCLES - 1);

    // ------------------------------------------------------------------
    // Geometry: operands widened by one bit so a hitbox near the right or
    // bottom screen edge can never wrap around and fake an overlap.
    // ------------------------------------------------------------------
    logic [10:0] w_bx, w_mx, w_bx_end, w_mx_end;
    logic [9:0]  w_by, w_my, w_by_end, w_my_end;
    logic        w_xov, w_yov, w_active, w_overlap, w_arm_cond, w_hit;

    assign w_bx     = {1'b0, barrel_x};
    assign w_mx     = {1'b0, mario_x};
    assign w_bx_end = w_bx + C_BW;
    assign w_mx_end = w_mx + C_MW;
    assign w_by     = {1'b0, barrel_y};
    assign w_my     = {1'b0, mario_y};
    assign w_by_end = w_by + C_BH;
    assign w_my_end = w_my + C_MH;

    // Strict compares: edges that merely touch do not overlap.
    assign w_xov     = (w_bx < w_mx_end) && (w_mx < w_bx_end);
    assign w_yov     = (w_by < w_my_end) && (w_my < w_by_end);
    assign w_active  = (barrel_state == 2'b01) || (barrel_state == 2'b10);
    assign w_overlap = w_xov && w_yov && w_active;

    // Mario is airborne, horizontally aligned, and entirely above the barrel.
    assign w_arm_cond = w_active && w_xov && !w_yov && mario_jump &&
                        (w_my_end <= w_by);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          over_q, over_d;
    logic [1:0]    lives_q, lives_d;
    logic [7:0]    score_q, score_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          armed_q, armed_d;
    logic          hit_q, hit_d;
    logic          xov_q, xov_d;

`ifdef BARREL_HIT_DEBOUNCE_EN
    // Second stage of the overlap pipeline: a hit needs two consecutive
    // registered overlap cycles, so one-cycle glitches are filtered out.
    logic hit_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_prev_q <= 1'b0;
        end else begin
            hit_prev_q <= hit_q;
        end
    end

    assign w_hit = hit_q && hit_prev_q;
`else
    assign w_hit = hit_q;
`endif

    always_comb begin
        state_d = state_q;
        over_d  = over_q;
        lives_d = lives_q;
        score_d = score_q;
        timer_d = timer_q;
        armed_d = armed_q;
        hit_d   = w_overlap;
        xov_d   = w_xov;

        case (state_q)
            ST_IDLE: begin
                armed_d = 1'b0;
                if (start) begin
                    state_d = ST_PLAY;
                    lives_d = C_LIVES;
                    score_d = 8'd0;
                    over_d  = 1'b0;
                end
            end

            ST_PLAY: begin
                if (w_hit) begin
                    // A hit outranks any pending jump-over in the same cycle.
                    armed_d = 1'b0;
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        timer_d = C_TIMER_LOAD;
                        state_d = ST_HIT;
                    end else begin
                        lives_d = 2'd0;
                        over_d  = 1'b1;
                        state_d = ST_OVER;
                    end
                end else if (!w_active) begin
                    armed_d = 1'b0;
                end else if (armed_q && xov_q && !w_xov) begin
                    // Mario has cleared the barrel horizontally while armed.
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    armed_d = 1'b0;
                end else if (w_arm_cond) begin
                    armed_d = 1'b1;
                end
            end

            ST_HIT: begin
                armed_d = 1'b0;
                if (timer_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_OVER: begin
                armed_d = 1'b0;
                over_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            over_q  <= 1'b0;
            lives_q <= 2'd0;
            score_q <= 8'd0;
            timer_q <= '0;
            armed_q <= 1'b0;
            hit_q   <= 1'b0;
            xov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            over_q  <= over_d;
            lives_q <= lives_d;
            score_q <= score_d;
            timer_q <= timer_d;
            armed_q <= armed_d;
            hit_q   <= hit_d;
            xov_q   <= xov_d;
        end
    end

    assign over      = over_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign hit_flash = (state_q == ST_HIT);

endmodule
`default_nettype wire

// File: tb/tb_barrel_hit_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_hit_detect
// Description : Self-checking bench for barrel_hit_detect. Directed scenarios
//               check fixed expected values; a randomized run is compared
//               against a cycle-level game model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_hit_detect;

    localparam int LIVES_P  = 3;
    localparam int BW_P     = 16;
    localparam int BH_P     = 16;
    localparam int MW_P     = 16;
    localparam int MH_P     = 16;
    localparam int INVULN_P = 50;
`ifdef BARREL_HIT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] barrel_x;
    logic [8:0] barrel_y;
    logic [1:0] barrel_state;
    logic [9:0] mario_x;
    logic [8:0] mario_y;
    logic       mario_jump;
    logic       over;
    logic [1:0] lives;
    logic [7:0] score;
    logic       hit_flash;

    int checks = 0;
    int errors = 0;

    barrel_hit_detect #(
        .LIVES        (LIVES_P),
        .BW           (BW_P),
        .BH           (BH_P),
        .MW           (MW_P),
        .MH           (MH_P),
        .INVULN_CYCLES(INVULN_P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .barrel_x    (barrel_x),
        .barrel_y    (barrel_y),
        .barrel_state(barrel_state),
        .mario_x     (mario_x),
        .mario_y     (mario_y),
        .mario_jump  (mario_jump),
        .over        (over),
        .lives       (lives),
        .score       (score),
        .hit_flash   (hit_flash)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: game rules evaluated once per clock edge.
    // Modes: 0 idle, 1 playing, 2 invulnerable, 3 game over.
    // history[0] = overlap seen at the last edge, history[1] = the one before.
    // ------------------------------------------------------------------
    int m_mode, m_lives, m_score, m_over, m_invuln_left, m_armed, m_prev_xov;
    int history [2];

    function automatic bit f_xov(int bx, int mx);
        return (bx < mx + MW_P) && (mx < bx + BW_P);
    endfunction

    function automatic bit f_yov(int by, int my);
        return (by < my + MH_P) && (my < by + BH_P);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_lives = 0; m_score = 0; m_over = 0;
        m_invuln_left = 0; m_armed = 0; m_prev_xov = 0;
        history[0] = 0; history[1] = 0;
    endtask

    task automatic model_step();
        int  bx, by, mx, my;
        bit  xo, yo, act, ovl, got_hit;
        bx = int'(barrel_x); by = int'(barrel_y);
        mx = int'(mario_x);  my = int'(mario_y);
        xo  = f_xov(bx, mx);
        yo  = f_yov(by, my);
        act = (barrel_state == 2'b01) || (barrel_state == 2'b10);
        ovl = xo && yo && act;
        got_hit = DEB ? (history[0] == 1 && history[1] == 1) : (history[0] == 1);
        if (m_mode == 0) begin
            m_armed = 0;
            if (start) begin
                m_mode = 1; m_lives = LIVES_P; m_score = 0; m_over = 0;
            end
        end else if (m_mode == 1) begin
            if (got_hit) begin
                m_armed = 0;
                if (m_lives > 1) begin
                    m_lives--; m_mode = 2; m_invuln_left = INVULN_P;
                end else begin
                    m_lives = 0; m_mode = 3; m_over = 1;
                end
            end else if (!act) begin
                m_armed = 0;
            end else if (m_armed == 1 && m_prev_xov == 1 && !xo) begin
                m_score = (m_score < 255) ? m_score + 1 : 255;
                m_armed = 0;
            end else if (xo && !yo && mario_jump && (my + MH_P <= by)) begin
                m_armed = 1;
            end
        end else if (m_mode == 2) begin
            m_armed = 0;
            m_invuln_left--;
            if (m_invuln_left == 0) m_mode = 1;
        end else begin
            m_armed = 0;
        end
        history[1] = history[0];
        history[0] = ovl;
        m_prev_xov = xo;
    endtask

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mario_far();
        mario_x = 10'd500; mario_y = 9'd100; mario_jump = 1'b0;
    endtask

    task automatic mario_on_barrel();
        mario_x = 10'd108; mario_y = 9'd196; mario_jump = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic start_play();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        start_play();
        ticks(3);
        // Assert reset between edges: outputs must clear without a clock.
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({over, lives, score, hit_flash} !== 12'd0) begin
            errors++;
            $display("FAIL reset_async: over=%0b lives=%0d score=%0d flash=%0b expected all 0",
                     over, lives, score, hit_flash);
        end
        ticks(2);
        checks++;
        if ({over, lives, score, hit_flash} !== 12'd0) begin
            errors++;
            $display("FAIL reset_held: over=%0b lives=%0d score=%0d flash=%0b expected all 0",
                     over, lives, score, hit_flash);
        end
        rst = 1'b0;
        tick();
        start_play();
        checks++;
        if (lives !== 2'(LIVES_P) || over !== 1'b0 || hit_flash !== 1'b0) begin
            errors++;
            $display("FAIL start_play: lives=%0d over=%0b flash=%0b expected lives=%0d over=0 flash=0",
                     lives, over, hit_flash, LIVES_P);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_nonfatal_hit();
        int  flash_cnt;
        bit  lives_moved;
        barrel_x = 10'd100; barrel_y = 9'd200; barrel_state = 2'b01;
        mario_on_barrel();
        tick();
        if (DEB) tick();
        checks++;
        if (lives !== 2'd3) begin
            errors++;
            $display("FAIL hit_latency_early: lives=%0d expected 3", lives);
        end
        tick();
        checks++;
        if (lives !== 2'd2 || hit_flash !== 1'b1) begin
            errors++;
            $display("FAIL hit_lives: lives=%0d flash=%0b expected lives=2 flash=1", lives, hit_flash);
        end
        mario_far();
        flash_cnt = 1;
        lives_moved = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!hit_flash) break;
            flash_cnt++;
            if (lives !== 2'd2) lives_moved = 1'b1;
        end
        checks++;
        if (flash_cnt != INVULN_P) begin
            errors++;
            $display("FAIL flash_length: flash cycles=%0d expected %0d", flash_cnt, INVULN_P);
        end
        checks++;
        if (lives_moved || lives !== 2'd2) begin
            errors++;
            $display("FAIL lives_during_hit: lives=%0d changed=%0b expected 2 unchanged",
                     lives, lives_moved);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fatal();
        int exp_l;
        do_reset();
        start_play();
        barrel_x = 10'd100; barrel_y = 9'd200; barrel_state = 2'b01;
        for (int h = 1; h <= 3; h++) begin
            mario_on_barrel();
            ticks(2);
            mario_far();
            ticks(60);
            exp_l = LIVES_P - h;
            checks++;
            if (lives !== 2'(exp_l) || over !== (h == 3)) begin
                errors++;
                $display("FAIL fatal_hit%0d: lives=%0d over=%0b expected lives=%0d over=%0b",
                         h, lives, over, exp_l, (h == 3));
            end
        end
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            tick();
            checks++;
            if (over !== 1'b1 || lives !== 2'd0) begin
                errors++;
                $display("FAIL over_sticky: cycle %0d over=%0b lives=%0d expected over=1 lives=0",
                         i, over, lives);
            end
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (over !== 1'b0) begin
            errors++;
            $display("FAIL over_clear: over=%0b expected 0", over);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_edge_touch();
        do_reset();
        start_play();
        barrel_x = 10'd100; barrel_y = 9'd200; barrel_state = 2'b01;
        mario_x = 10'd116; mario_y = 9'd200; mario_jump = 1'b0;
        ticks(10);
        checks++;
        if (lives !== 2'd3) begin
            errors++;
            $display("FAIL edge_touch: lives=%0d expected 3", lives);
        end
        mario_x = 10'd115;
        ticks(4);
        checks++;
        if (lives !== 2'd2) begin
            errors++;
            $display("FAIL edge_overlap: lives=%0d expected 2", lives);
        end
        mario_far();
        ticks(60);
    endtask

    // ------------------------------------------------------------------
    task automatic test_hit_filter();
        do_reset();
        start_play();
        barrel_x = 10'd100; barrel_y = 9'd200; barrel_state = 2'b01;
        mario_on_barrel();
        tick();
        mario_far();
        ticks(5);
        checks++;
        if (lives !== (DEB ? 2'd3 : 2'd2)) begin
            errors++;
            $display("FAIL single_pulse: lives=%0d expected %0d", lives, DEB ? 3 : 2);
        end
        ticks(60);
        do_reset();
        start_play();
        mario_on_barrel();
        tick();
        tick();
        mario_far();
        checks++;
        if (lives !== (DEB ? 2'd3 : 2'd2)) begin
            errors++;
            $display("FAIL two_cycle_mid: lives=%0d expected %0d", lives, DEB ? 3 : 2);
        end
        tick();
        checks++;
        if (lives !== 2'd2) begin
            errors++;
            $display("FAIL two_cycle_hit: lives=%0d expected 2", lives);
        end
        ticks(60);
    endtask

    // ------------------------------------------------------------------
    task automatic test_jump_over();
        do_reset();
        start_play();
        barrel_x = 10'd100; barrel_y = 9'd200; barrel_state = 2'b01;
        mario_y = 9'd184; mario_jump = 1'b1;
        for (int pass = 1; pass <= 2; pass++) begin
            for (int x = 80; x <= 130; x++) begin
                mario_x = 10'(x);
                tick();
            end
            checks++;
            if (score !== 8'(pass) || lives !== 2'd3) begin
                errors++;
                $display("FAIL jump_pass%0d: score=%0d lives=%0d expected score=%0d lives=3",
                         pass, score, lives, pass);
            end
        end
        for (int p = 0; p < 253; p++) begin
            mario_x = 10'd110; tick();
            mario_x = 10'd120; tick();
        end
        checks++;
        if (score !== 8'd255 || score !== 8'(m_score)) begin
            errors++;
            $display("FAIL jump_reach_255: score=%0d expected 255", score);
        end
        for (int x = 80; x <= 130; x++) begin
            mario_x = 10'(x);
            tick();
        end
        checks++;
        if (score !== 8'd255 || lives !== 2'd3) begin
            errors++;
            $display("FAIL jump_saturate: score=%0d lives=%0d expected score=255 lives=3",
                     score, lives);
        end
        mario_far();
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        int mx, r;
        logic [11:0] exp_v;
        do_reset();
        start_play();
        barrel_x = 10'd100; barrel_y = 9'd200; barrel_state = 2'b01;
        mx = 60;
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 399) begin
                do_reset();
                start_play();
            end
            mx = mx + int'($urandom_range(0, 8)) - 4;
            if (mx < 60)  mx = 60;
            if (mx > 150) mx = 150;
            mario_x = 10'(mx);
            if ($urandom_range(0, 15) == 0) begin
                r = int'($urandom_range(0, 3));
                mario_y = (r == 0) ? 9'd196 : (r == 1) ? 9'd184 : 9'd150;
            end
            mario_jump = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                r = int'($urandom_range(0, 9));
                barrel_state = (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            end
            start = ($urandom_range(0, 7) == 0);
            tick();
            exp_v = {1'(m_over), 2'(m_lives), 8'(m_score), 1'(m_mode == 2)};
            checks++;
            if ({over, lives, score, hit_flash} !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: over=%0b lives=%0d score=%0d flash=%0b expected over=%0b lives=%0d score=%0d flash=%0b",
                         i, over, lives, score, hit_flash,
                         exp_v[11], exp_v[10:9], exp_v[8:1], exp_v[0]);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        barrel_x = 10'd100; barrel_y = 9'd200; barrel_state = 2'b00;
        mario_far();
        model_reset();
        @(negedge clk);
        test_reset();
        test_nonfatal_hit();
        test_fatal();
        test_edge_touch();
        test_hit_filter();
        test_jump_over();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/barrel_hit_detect.md
Name: barrel_hit_detect

Overview:
- Consumes the barrel block's position and state outputs, together with Mario's position and jump flag.
- Decides each cycle whether Mario has been hit by the barrel or has jumped over it.
- Tracks remaining lives and a jump-over score.
- Drives the `over` signal back into the barrel block, making it the game-side responder on the barrel interface.

Parameters:
- LIVES, 3: lives loaded on start (1..3).
- BW, 16: barrel hitbox width, pixels.
- BH, 16: barrel hitbox height, pixels.
- MW, 16: Mario hitbox width, pixels.
- MH, 16: Mario hitbox height, pixels.
- INVULN_CYCLES, 50: cycles of invulnerability after a non-fatal hit (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  level; begins play from IDLE
- barrel_x  input  10  barrel top-left x
- barrel_y  input  9  barrel top-left y
- barrel_state  input  2  00 idle, 01 rolling, 10 falling, 11 gone
- mario_x  input  10  Mario top-left x
- mario_y  input  9  Mario top-left y
- mario_jump  input  1  Mario airborne
- over  output  1  game over, to barrel.over
- lives  output  2  remaining lives
- score  output  8  barrels jumped, saturating
- hit_flash  output  1  high during the HIT state

Behaviour:
- Reset (async, any state, takes effect immediately):
  - state=IDLE, over=0, lives=0, score=0, hit_flash=0, hit_q=0, armed=0, timer=0.
- Geometry (combinational, zero-extended; x terms 11 bits, y terms 10 bits, no wrap):
  - xov = (barrel_x < mario_x+MW) && (mario_x < barrel_x+BW)
  - yov = (barrel_y < mario_y+MH) && (mario_y < barrel_y+BH)
  - Edges that only touch are not overlap.
- active = barrel_state is 01 or 10. Overlap = xov && yov && active.
- hit_q: registered copy of overlap.
- States:
  - IDLE:
    - start=1 → PLAY; lives=LIVES, score=0, over=0.
  - PLAY, on hit_q=1:
    - If lives>1: lives-1, → HIT, timer=INVULN_CYCLES-1, armed=0.
    - If lives==1: lives=0, → OVER, over=1.
  - HIT:
    - hit_flash=1 and overlap is ignored.
    - timer decrements each cycle; at timer==0 → PLAY.
    - An overlap still present on return to PLAY registers as a new hit.
  - OVER:
    - over held at 1; start ignored; leaves OVER only via rst.
- Latency: overlap present before edge k → hit_q=1 after edge k → lives/state/over update after edge k+1.
- Scoring (PLAY only):
  - armed set when active && xov && !yov && mario_jump && mario_y+MH ≤ barrel_y.
  - While armed, falling xov → score+1 (saturates at 255), armed=0.
  - A hit in the same cycle takes priority: armed cleared, no score.
  - barrel_state 00 or 11 clears armed.
- start held high during PLAY, HIT or OVER has no effect.
- Out-of-range overlap from large x/y is impossible given the widened compares.

Optional Feature:
- Macro: BARREL_HIT_DEBOUNCE_EN.
- Defined:
  - A hit requires overlap in two consecutive cycles: hit_q must be 1 on two consecutive edges.
  - A single-cycle overlap glitch causes no hit.
  - Latency increases by one cycle (update after edge k+2).
- Undefined: a single registered overlap cycle is a hit, with latency as above.

Test Plan:
- Reset/start:
  - Stimulus: rst=1 mid-PLAY, then rst=0, then start=1 for one cycle.
  - Response: while rst high, over=0, lives=0, score=0; one edge after start, lives=3, state PLAY.
- Non-fatal hit:
  - Stimulus: barrel (100,200) rolling, Mario (108,196), overlap held.
  - Response: lives 3→2 two edges after overlap begins; hit_flash high for exactly 50 cycles; lives unchanged during that window.
- Fatal sequence:
  - Stimulus: three hits separated by ≥51 cycles.
  - Response: lives 3→2→1→0; over=1 after the third hit and stays 1 while start toggles; cleared only by rst.
- Edge touch:
  - Stimulus: barrel_x=100, mario_x=116, same y.
  - Response: no hit, lives stays 3.
  - Stimulus: mario_x=115.
  - Response: hit.
- Jump-over:
  - Stimulus: barrel (100,200) rolling; Mario at y=184, jump=1, x sweeps 80→130.
  - Response: score=1, lives=3; a second pass gives score=2.
  - Stimulus: preload score 255, then another pass.
  - Response: score stays 255.
- Debounce (macro defined):
  - Stimulus: single-cycle overlap pulse.
  - Response: no hit.
  - Stimulus: two-cycle overlap.
  - Response: lives decrements three edges after overlap start.
